// File: rtl/ex_muldiv_pkg.sv
// Shared execute-stage definitions: ALU constants, M-extension op encodings,
// multiply/divide FSM state encoding and the default datapath width.
package ex_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Base ALU operation encodings used by the integer execute unit.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // M-extension funct3 encodings.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // rs1 is treated as signed by every op except the fully unsigned ones.
  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU keeps rs2 unsigned).
  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Sequencing (step count) is owned by the parent; this block only holds the
// partial remainder / quotient and exposes the post-step values so the
// parent can register the final result on the last step.
module ex_div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            take;

  // Shift the next dividend bit into the remainder and trial-subtract.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
    take      = ~diff[XLEN];
    rem_nxt_o = take ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_nxt_o = {quo_q[XLEN-2:0], take};
  end

  // Load operands at accept, then advance one bit per enabled step.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative M-extension unit: shift-add multiplier (inline) and restoring
// divider (ex_div_iter), both on operand magnitudes with a final sign fix.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
// Handshake: start_i is accepted only in IDLE with flush_i low and rdy_in
// high; the result is valid for the single cycle done_o is high, while
// rd_data_o / rd_addr_o hold their last value at all other times.
// flush_i kills the operation even while rdy_in is low; rst_in beats both.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_write_enable_o,
  output muldiv_state_t         state_o
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t          state;
  logic [CNT_W-1:0]       count;
  logic [2:0]             op_q;
  logic [REG_ADDR_W-1:0]  rd_addr_q;
  logic                   neg_q;      // negate product / quotient
  logic                   neg_r;      // negate remainder (follows dividend)
  logic [XLEN-1:0]        mcand_q;    // multiplicand magnitude
  logic [2*XLEN-1:0]      prod_q;     // {partial sum, remaining multiplier}

  logic                   rs1_neg;
  logic                   rs2_neg;
  logic [XLEN-1:0]        rs1_mag;
  logic [XLEN-1:0]        rs2_mag;
  logic                   div_zero;
  logic                   div_ovf;
  logic                   special;
  logic [XLEN-1:0]        special_res;

  logic [XLEN:0]          mul_sum;
  logic [2*XLEN-1:0]      prod_nxt;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        quo_nxt;
  logic [XLEN-1:0]        rem_nxt;
  logic [XLEN-1:0]        quo_fix;
  logic [XLEN-1:0]        rem_fix;
  logic [XLEN-1:0]        calc_res;
  logic                   div_load;
  logic                   div_step;

  // Decode the incoming request: operand magnitudes and one-cycle cases.
  always_comb begin
    rs1_neg  = op_rs1_signed(op_i) & rs1_data_i[XLEN-1];
    rs2_neg  = op_rs2_signed(op_i) & rs2_data_i[XLEN-1];
    rs1_mag  = rs1_neg ? -rs1_data_i : rs1_data_i;
    rs2_mag  = rs2_neg ? -rs2_data_i : rs2_data_i;
    div_zero = op_i[2] & (rs2_data_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    special  = div_zero | div_ovf;
    // op_i[1] separates remainder ops from quotient ops.
    if (div_zero) special_res = op_i[1] ? rs1_data_i : '1;
    else          special_res = op_i[1] ? '0 : rs1_data_i;
  end

  // One shift-add multiply step and the sign-corrected final results.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    prod_fix = neg_q ? -prod_nxt : prod_nxt;
    quo_fix  = neg_q ? -quo_nxt : quo_nxt;
    rem_fix  = neg_r ? -rem_nxt : rem_nxt;
    case (op_q)
      OP_MUL:             calc_res = prod_fix[XLEN-1:0];
      OP_DIV, OP_DIVU:    calc_res = quo_fix;
      OP_REM, OP_REMU:    calc_res = rem_fix;
      default:            calc_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  assign div_load = rdy_in & ~flush_i & (state == ST_IDLE) & start_i;
  assign div_step = rdy_in & ~flush_i & (state == ST_CALC);

  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (rs1_mag),
    .divisor_i  (rs2_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Control FSM plus multiplier datapath and registered result outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      count     <= '0;
      done_o    <= 1'b0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      op_q      <= OP_MUL;
      rd_addr_q <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
    end else if (flush_i) begin
      state  <= ST_IDLE;
      done_o <= 1'b0;
    end else if (rdy_in) begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            rd_addr_q <= rd_addr_i;
            neg_q     <= rs1_neg ^ rs2_neg;
            neg_r     <= rs1_neg;
            mcand_q   <= rs1_mag;
            prod_q    <= {{XLEN{1'b0}}, rs2_mag};
            if (special) begin
              state     <= ST_DONE;
              done_o    <= 1'b1;
              rd_data_o <= special_res;
              rd_addr_o <= rd_addr_i;
            end else begin
              state <= ST_CALC;
              count <= CNT_W'(XLEN-1);
            end
          end
        end
        ST_CALC: begin
          prod_q <= prod_nxt;
          if (count == '0) begin
            state     <= ST_DONE;
            done_o    <= 1'b1;
            rd_data_o <= calc_res;
            rd_addr_o <= rd_addr_q;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o            = (state != ST_IDLE);
  assign stall_o           = (start_i & (state == ST_IDLE)) | (state == ST_CALC);
  assign rd_write_enable_o = done_o & (rd_addr_o != '0);
  assign state_o           = state;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: spec vector table, random ops against an arithmetic
// reference model, and hand sequences for flush, pause, ignored start,
// mid-operation reset and a 16-bit instance.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_in, rdy_in, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr_i;
  logic        busy, stall, done, we;
  logic [31:0] rd_data;
  logic [4:0]  rd_addr;
  muldiv_state_t st;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic [4:0]  rdi16;
  logic        busy16, stall16, done16, we16;
  logic [15:0] rd_data16;
  logic [4:0]  rd_addr16;
  muldiv_state_t st16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .start_i(start_i),
    .op_i(op_i), .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy), .stall_o(stall), .done_o(done),
    .rd_data_o(rd_data), .rd_addr_o(rd_addr), .rd_write_enable_o(we),
    .state_o(st)
  );

  ex_muldiv #(.XLEN(16), .REG_ADDR_W(5)) dut16 (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(1'b1), .start_i(start16),
    .op_i(op16), .rs1_data_i(a16), .rs2_data_i(b16), .rd_addr_i(rdi16),
    .flush_i(1'b0), .busy_o(busy16), .stall_o(stall16), .done_o(done16),
    .rd_data_o(rd_data16), .rd_addr_o(rd_addr16), .rd_write_enable_o(we16),
    .state_o(st16)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = sa * sb;                       return p[31:0];  end
      OP_MULH:   begin p = sa * sb;                       return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'({32'b0, b});     return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b};       return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    op_i = op; rs1 = a; rs2 = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Latency counts the cycle right after the accepting edge as 1.
  task automatic wait_done(input int inject_at, input int pause_at, input int pause_len, output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (lat == inject_at) begin
        start_i = 1'b1; op_i = OP_REMU; rs1 = 32'h1234; rs2 = 32'd3; rd_addr_i = 5'd9;
      end else begin
        start_i = 1'b0;
      end
      rdy_in = !(lat >= pause_at && lat < pause_at + pause_len);
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    rdy_in  = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                        input int exp_lat, input int inject_at, input int pause_at, input int pause_len);
    int          lat;
    logic [31:0] exp;
    exp_q.push_back(exp_data);
    send(op, a, b, rd);
    wait_done(inject_at, pause_at, pause_len, lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    exp = exp_q.pop_front();
    if (done) begin
      check({name, " data"}, rd_data, exp);
      check({name, " addr"}, rd_addr, rd);
      check({name, " we"}, we, rd != 0);
      check({name, " busy_in_done"}, busy, 1);
      @(posedge clk); #1;
      check({name, " done_one_cycle"}, done, 0);
      check({name, " idle_after"}, busy, 0);
      check({name, " data_held"}, rd_data, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          lat;
    int          done_cnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int          sel;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
    vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
    vecs[4]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 33};
    vecs[5]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 1};
    vecs[6]  = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h0,         1};
    vecs[7]  = '{OP_DIVU,   32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1};
    vecs[8]  = '{OP_REMU,   32'd5,          32'd0,         5'd0,  32'd5,         1};
    vecs[9]  = '{OP_DIV,    32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1};
    vecs[10] = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd11, 32'h4000_0000, 33};
    vecs[11] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd12, 32'hFFFF_FFFF, 33};
    vecs[12] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd13, 32'd1,         33};

    rst_in = 1'b1; rdy_in = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'b0; rs1 = '0; rs2 = '0; rd_addr_i = '0;
    start16 = 1'b0; op16 = 3'b0; a16 = '0; b16 = '0; rdi16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset done", done, 0);
    check("reset rd_data", rd_data, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset busy", busy, 0);
    check("reset we", we, 0);
    check("reset state", 64'(st), 64'(ST_IDLE));
    @(negedge clk);
    rst_in = 1'b0;

    // spec vectors
    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat, -1, -1, 0);

    // random ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      rrd = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rrd,
             model(rop, ra, rb), model_lat(rop, ra, rb), -1, -1, 0);
    end

    // start during CALC is ignored
    run_op("ignore_start", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33, 5, -1, 0);

    // rdy_in low for 5 cycles stretches latency by 5
    run_op("pause", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4,
           model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 38, -1, 8, 5);

    // flush mid-CALC
    send(OP_MUL, 32'd3, 32'd4, 5'd5);
    repeat (9) @(posedge clk);
    #1;
    check("flush pre state", 64'(st), 64'(ST_CALC));
    check("flush pre stall", stall, 1);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1;
    check("flush state", 64'(st), 64'(ST_IDLE));
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    // flush together with start in IDLE does not accept
    @(negedge clk); start_i = 1'b1; op_i = OP_MUL; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    check("flush+start busy", busy, 0);
    start_i = 1'b0; flush_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("flush no done", 64'(done_cnt), 0);
    check("flush data held", rd_data, 32'd14 * 0 + model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

    // reset mid-CALC
    send(OP_MUL, 32'd7, 32'd9, 5'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_in = 1'b1;
    @(posedge clk); #1;
    check("rst done", done, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst busy", busy, 0);
    check("rst state", 64'(st), 64'(ST_IDLE));
    @(negedge clk); rst_in = 1'b0;
    run_op("after_rst", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, -1, -1, 0);

    // 16-bit instance
    @(negedge clk);
    start16 = 1'b1; op16 = OP_MUL; a16 = 16'd7; b16 = 16'hFFFD; rdi16 = 5'd2;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("x16 latency", 64'(lat), 17);
    check("x16 data", rd_data16, 16'hFFEB);
    check("x16 we", we16, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand/result width (legal: 8..64, even).
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the destination register address width.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 rdy_in  input  1  global pause; when low, all state holds.
REQ-006 start_i  input  1  issue request, accepted only in IDLE.
REQ-007 op_i  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1_data_i / rs2_data_i  input  XLEN  operands, sampled at accept.
REQ-009 rd_addr_i  input  REG_ADDR_W  destination, sampled at accept.
REQ-010 flush_i  input  1  misprediction kill; aborts any operation.
REQ-011 busy_o  output  1  high in CALC and DONE.
REQ-012 stall_o  output  1  combinational: (start_i & IDLE) | CALC; holds upstream pipeline.
REQ-013 done_o  output  1  one-cycle result-valid pulse.
REQ-014 rd_data_o  output  XLEN  result, valid while done_o.
REQ-015 rd_addr_o  output  REG_ADDR_W  captured destination.
REQ-016 rd_write_enable_o  output  1  done_o & (rd_addr_o != 0).

Function
REQ-017 FSM states SHALL be IDLE, CALC, DONE; rdy_in low freezes state, counter and datapath.
REQ-018 IDLE: start_i & !flush_i SHALL capture op, operands, rd_addr; a special case (REQ-022/023) goes to DONE, otherwise to CALC with counter = XLEN-1.
REQ-019 CALC SHALL process one bit per cycle (shift-add multiply, restoring divide on magnitudes); at counter 0 go to DONE.
REQ-020 Latency: accept at edge T -> done_o high in cycle T+XLEN+1 (normal) or T+1 (special case), for exactly one cycle, then IDLE.
REQ-021 Signed ops SHALL use operand magnitudes and negate the result when signs differ; REM sign follows dividend; MULHSU treats rs2 as unsigned.
REQ-022 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
REQ-023 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = rs1, REM = 0.
REQ-024 MUL returns low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits.
REQ-025 start_i while busy_o SHALL be ignored (no capture, no effect on current operation).
REQ-026 flush_i in any state SHALL return to IDLE next edge with done_o low; flush_i together with start_i in IDLE SHALL not accept.
REQ-027 rd_data_o, rd_addr_o SHALL be registered and hold their value outside done_o.

Reset
REQ-028 rst_in SHALL force IDLE, counter 0, done_o 0, rd_data_o 0, rd_addr_o 0 next edge, aborting any operation; rst_in overrides rdy_in and flush_i.

Structure
REQ-029 Op encodings, FSM state encoding and XLEN default SHALL live in the shared defines package with existing ALU constants.
REQ-030 Divider datapath SHALL be sub-module ex_div_iter (shared counter); multiplier stays inline.

Verification
REQ-031 MUL 7 x -3 (XLEN=32) -> done_o at T+33, rd_data_o = 0xFFFFFFEB.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rd_data_o = 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIV 0x80000000 / -1 -> 0x80000000 at T+1.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF at T+1; REMU 5 / 0 -> 5; rd_addr 0 -> rd_write_enable_o 0.
REQ-035 flush_i at CALC cycle 10 -> IDLE next edge, no done_o; start_i during CALC ignored; rdy_in low 5 cycles -> done_o delayed exactly 5 cycles.
REQ-036 rst_in mid-CALC -> all outputs 0 next edge; XLEN=16 rerun of REQ-031 -> 0xFFEB at T+17.
